// File: rtl/dio_download_bridge.sv
// Download bridge: packs the hps_io ioctl byte stream into 16-bit SDRAM words,
// maps each file index to its word region, holds ioctl_wait until the word has
// been written in a dioBusControl slot, and latches floppy size flags when the
// download ends.
module dio_download_bridge #(
  parameter logic [20:0] ROM_BASE = 21'h000000,
  parameter logic [20:0] INT_BASE = 21'h080000,
  parameter logic [20:0] EXT_BASE = 21'h100000,
  parameter int unsigned DS_BYTES = 819200,
  parameter int unsigned SS_BYTES = 409600
) (
  input  logic        clk,
  input  logic        _systemReset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        dioBusControl,
  output logic        download_cycle,
  output logic        dio_write,
  output logic [20:0] dio_a,
  output logic [15:0] dio_data,
  input  logic [1:0]  diskEject,
  output logic [1:0]  insertDisk,
  output logic [1:0]  diskSides
);

  typedef enum logic [1:0] {IDLE, PEND, ARMED, WRITE} state_t;

  state_t      state_q, state_d;
  logic        ioctl_wait_d;
  logic        dio_write_d;
  logic [20:0] dio_a_d;
  logic [15:0] dio_data_d;
  logic [7:0]  temp_q, temp_d;
  logic        temp_valid_q, temp_valid_d;
  logic [24:0] last_byte_q, last_byte_d;
  logic        download_q;
  logic        int_ds_q, int_ds_d, int_ss_q, int_ss_d;
  logic        ext_ds_q, ext_ds_d, ext_ss_q, ext_ss_d;

  logic [20:0] base;
  logic        idx_ok;
  logic        dl_fall;
  logic [24:0] n_bytes;
  logic        is_ds, is_ss;

  // Region base for the current file index; indices above 2 emit no words.
  always_comb begin
    base   = ROM_BASE;
    idx_ok = 1'b1;
    case (ioctl_index)
      8'd0:    base = ROM_BASE;
      8'd1:    base = INT_BASE;
      8'd2:    base = EXT_BASE;
      default: idx_ok = 1'b0;
    endcase
  end

  assign dl_fall = download_q & ~ioctl_download;
  assign n_bytes = last_byte_q + 25'd1;
  assign is_ds   = (n_bytes == 25'(DS_BYTES));
  assign is_ss   = (n_bytes == 25'(SS_BYTES));

  // Next-state logic: byte packing, slot handshake, size flags and eject.
  always_comb begin
    state_d      = state_q;
    ioctl_wait_d = ioctl_wait;
    dio_write_d  = dio_write;
    dio_a_d      = dio_a;
    dio_data_d   = dio_data;
    temp_d       = temp_q;
    temp_valid_d = temp_valid_q;
    last_byte_d  = last_byte_q;
    int_ds_d     = int_ds_q;
    int_ss_d     = int_ss_q;
    ext_ds_d     = ext_ds_q;
    ext_ss_d     = ext_ss_q;

    case (state_q)
      IDLE: begin
        if (ioctl_wr) begin
          last_byte_d = ioctl_addr;
          if (!ioctl_addr[0]) begin
            temp_d       = ioctl_dout;
            temp_valid_d = 1'b1;
          end else begin
            temp_valid_d = 1'b0;
            if (idx_ok) begin
              dio_data_d   = {temp_q, ioctl_dout};
              dio_a_d      = base + ioctl_addr[21:1];
              state_d      = PEND;
              ioctl_wait_d = 1'b1;
            end
          end
        end else if (dl_fall && temp_valid_q) begin
          // Flush an unpaired trailing even byte as {byte, 00}.
          temp_valid_d = 1'b0;
          if (idx_ok) begin
            dio_data_d   = {temp_q, 8'h00};
            dio_a_d      = base + last_byte_q[21:1];
            state_d      = PEND;
            ioctl_wait_d = 1'b1;
          end
        end
      end
      PEND: begin
        if (!dioBusControl) begin
          state_d     = ARMED;
          dio_write_d = 1'b1;
        end
      end
      ARMED: begin
        if (dioBusControl) state_d = WRITE;
      end
      WRITE: begin
        if (!dioBusControl) begin
          state_d      = IDLE;
          dio_write_d  = 1'b0;
          ioctl_wait_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (dl_fall) begin
      case (ioctl_index)
        8'd1: begin
          int_ds_d = is_ds;
          int_ss_d = is_ss;
        end
        8'd2: begin
          ext_ds_d = is_ds;
          ext_ss_d = is_ss;
        end
        default: ;
      endcase
    end

    // Eject overrides a same-edge size latch.
    if (diskEject[0]) begin
      int_ds_d = 1'b0;
      int_ss_d = 1'b0;
    end
    if (diskEject[1]) begin
      ext_ds_d = 1'b0;
      ext_ss_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!_systemReset) begin
      state_q      <= IDLE;
      ioctl_wait   <= 1'b0;
      dio_write    <= 1'b0;
      dio_a        <= '0;
      dio_data     <= '0;
      temp_q       <= '0;
      temp_valid_q <= 1'b0;
      last_byte_q  <= '0;
      download_q   <= 1'b0;
      int_ds_q     <= 1'b0;
      int_ss_q     <= 1'b0;
      ext_ds_q     <= 1'b0;
      ext_ss_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ioctl_wait   <= ioctl_wait_d;
      dio_write    <= dio_write_d;
      dio_a        <= dio_a_d;
      dio_data     <= dio_data_d;
      temp_q       <= temp_d;
      temp_valid_q <= temp_valid_d;
      last_byte_q  <= last_byte_d;
      download_q   <= ioctl_download;
      int_ds_q     <= int_ds_d;
      int_ss_q     <= int_ss_d;
      ext_ds_q     <= ext_ds_d;
      ext_ss_q     <= ext_ss_d;
    end
  end

  assign download_cycle = ioctl_download & dioBusControl;
  assign insertDisk     = {ext_ds_q | ext_ss_q, int_ds_q | int_ss_q};
  assign diskSides      = {ext_ds_q, int_ds_q};

endmodule
